// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared FFT reorder definitions: FSM state encoding, frame
//               length derivation and a width-generic bit reversal helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_FILL   = 2'd1;
    localparam state_t ST_STREAM = 2'd2;

    // Last counter value of a frame of 2**addr_w samples.
    function automatic int unsigned frame_max(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] value,
                                           input int unsigned width);
        logic [31:0] result;
        result = '0;
        for (int unsigned i = 0; i < width && i < 32; i++) begin
            result[5'(width - 1 - i)] = value[5'(i)];
        end
        return result;
    endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/bitrev_addr.sv
`default_nettype none
// ============================================================================
// Module      : bitrev_addr
// Description : Combinational width-generic bit reverser for reorder buffers.
// Revision    : 1.0 - initial release
// ============================================================================
module bitrev_addr #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] addr_in,
    output logic [WIDTH-1:0] addr_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign addr_out[i] = addr_in[WIDTH-1-i];
    end

endmodule : bitrev_addr
`default_nettype wire

// File: rtl/bitrev_reader.sv
`default_nettype none
// ============================================================================
// Module      : bitrev_reader
// Description : Bit-reversed read address generator for the biplex FFT
//               reorder buffer, one frame behind the natural-order writer.
//               Define BITREV_READER_PINGPONG_EN for a bank bit on rd_addr.
// Revision    : 1.0 - initial release
// ============================================================================
module bitrev_reader
    import fft_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_in,
`ifdef BITREV_READER_PINGPONG_EN
    output logic [ADDR_W:0]   rd_addr,
`else
    output logic [ADDR_W-1:0] rd_addr,
`endif
    output logic              rd_valid,
    output logic              sync_out,
    output logic              frame_err
);

`ifdef BITREV_READER_PINGPONG_EN
    localparam int RD_W = ADDR_W + 1;
`else
    localparam int RD_W = ADDR_W;
`endif
    localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(frame_max(ADDR_W));

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] cnt_rev;
    logic [RD_W-1:0]   rd_addr_q, rd_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              sync_out_q, sync_out_d;
    logic              frame_err_q, frame_err_d;
    logic              resync;
`ifdef BITREV_READER_PINGPONG_EN
    logic              bank_q, bank_d;
`endif

    bitrev_addr #(
        .WIDTH    (ADDR_W)
    ) u_bitrev_addr (
        .addr_in  (cnt_q),
        .addr_out (cnt_rev)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_addr_d   = rd_addr_q;
        rd_valid_d  = 1'b0;
        sync_out_d  = 1'b0;
        frame_err_d = frame_err_q;
`ifdef BITREV_READER_PINGPONG_EN
        bank_d      = bank_q;
`endif
        // A frame start seen anywhere but count 0 means the writer moved on
        // without us; the sync sample itself becomes sample 0 of a new fill.
        resync = en && sync_in && (state_q != ST_IDLE) && (cnt_q != '0);

        if (resync) begin
            frame_err_d = 1'b1;
            cnt_d       = ADDR_W'(1);
            state_d     = ST_FILL;
`ifdef BITREV_READER_PINGPONG_EN
            bank_d      = 1'b0;
`endif
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (sync_in) begin
                        cnt_d   = ADDR_W'(1);
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == CNT_MAX) begin
                        state_d = ST_STREAM;
                    end
                end
                ST_STREAM: begin
`ifdef BITREV_READER_PINGPONG_EN
                    rd_addr_d = {bank_q, cnt_rev};
                    if (cnt_q == CNT_MAX) begin
                        bank_d = ~bank_q;
                    end
`else
                    rd_addr_d = cnt_rev;
`endif
                    rd_valid_d = 1'b1;
                    sync_out_d = (cnt_q == '0);
                    cnt_d      = cnt_q + ADDR_W'(1);
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            sync_out_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef BITREV_READER_PINGPONG_EN
            bank_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_addr_q   <= rd_addr_d;
            rd_valid_q  <= rd_valid_d;
            sync_out_q  <= sync_out_d;
            frame_err_q <= frame_err_d;
`ifdef BITREV_READER_PINGPONG_EN
            bank_q      <= bank_d;
`endif
        end
    end

    assign rd_addr   = rd_addr_q;
    assign rd_valid  = rd_valid_q;
    assign sync_out  = sync_out_q;
    assign frame_err = frame_err_q;

endmodule : bitrev_reader
`default_nettype wire

// File: doc/bitrev_reader.md
Name: bitrev_reader

Overview:
- Read-side address generator for the biplex FFT reorder buffer; the counter on the write side fills the buffer in natural order.
- Tracks the writer's frame position from `sync_in` and `en`, then issues bit-reversed read addresses in lockstep with the writer, one frame behind.
- Sits between the reorder RAM read port and the downstream FFT stage.
- Flags frame misalignment.

Parameters:
- ADDR_W, 6, log2 of frame length (64-point default); sets the address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- en  in  1  sample-valid strobe shared with the writer; qualifies every count step
- sync_in  in  1  frame-start pulse from the writer, coincident with the writer's count 0; only meaningful when en=1
- rd_addr  out  ADDR_W (ADDR_W+1 with PINGPONG_EN)  registered bit-reversed read address
- rd_valid  out  1  rd_addr is valid this cycle
- sync_out  out  1  one-cycle pulse marking the first read address (index 0) of each output frame
- frame_err  out  1  sticky flag: sync_in arrived off a frame boundary

Behaviour:
- State reg, values IDLE / FILL / STREAM. Counter cnt is ADDR_W bits, unsigned, wraps 2^ADDR_W-1 -> 0.
- Reset (rst=0 at a rising edge):
  - state=IDLE, cnt=0.
  - rd_addr=0, rd_valid=0, sync_out=0, frame_err=0.
  - Reset mid-frame aborts immediately; no partial output follows.
- IDLE:
  - cnt held at 0; outputs held low.
  - On sync_in & en: cnt<=1 (sample 0 consumed), state<=FILL.
  - sync_in with en=0 is ignored.
- FILL:
  - On en: cnt<=cnt+1.
  - When cnt==2^ADDR_W-1 & en: cnt<=0 and state<=STREAM.
  - rd_valid stays 0 throughout FILL.
- STREAM, on every cycle with en=1:
  - rd_addr<=bitrev(cnt), i.e. bit i of cnt maps to bit ADDR_W-1-i.
  - rd_valid<=1.
  - sync_out<=(cnt==0).
  - cnt<=cnt+1, wrapping.
- STREAM with en=0: rd_valid<=0, sync_out<=0, rd_addr and cnt hold.
- Latency: exactly 1 clk from a qualifying en to rd_addr/rd_valid.
- Frames stream back-to-back indefinitely; no gap at the wrap.
- sync_in & en in FILL or STREAM:
  - If cnt==0: aligned, no action.
  - Else: frame_err<=1 and a resync — cnt<=1, state<=FILL, rd_valid<=0 that cycle.
- frame_err clears only on reset.
- sync_in with en=0 in any state: ignored.
- Simultaneous resync and the wrap (cnt==MAX, sync_in, en): the resync wins and frame_err is set.

Optional Feature:
- Macro: BITREV_READER_PINGPONG_EN.
- Defined:
  - rd_addr widens to ADDR_W+1; the MSB is a bank bit.
  - The bank bit is 0 in the first STREAM frame and toggles each time cnt wraps 2^ADDR_W-1 -> 0 while in STREAM.
  - Resync or reset returns the bank bit to 0.
- Undefined:
  - rd_addr is ADDR_W bits, with a single in-place bank.
  - Downstream must guarantee read-before-write.

Decomposition:
- Shared package `fft_pkg`:
  - state enum type (IDLE/FILL/STREAM);
  - `bitrev` function parameterised on width;
  - frame-length constant derivation (2**ADDR_W - 1).
- One sub-module is natural: `bitrev_addr`, a combinational width-generic bit reverser, reused by other reorder blocks.
- The FSM and counter stay in `bitrev_reader`.

Test Plan:
- ADDR_W=3, rst=0 for 2 clk then 1, en=1, sync_in pulse at cycle 0 -> rd_valid=0 for cycles 1..8; rd_addr sequence 0,4,2,6,1,5,3,7 on cycles 9..16; sync_out=1 only at cycle 9; the sequence repeats from cycle 17.
- Same setup with en toggling 1,0,1,0 -> rd_addr advances only one cycle after each en=1; rd_valid mirrors en delayed by 1; the address is held during gaps.
- In STREAM, inject sync_in&en at cnt=5 -> frame_err=1 next cycle, rd_valid=0 for the following 7 qualified samples, then the sequence restarts at 0 with sync_out.
- Aligned sync_in at every frame boundary for 4 frames -> frame_err stays 0; output is uninterrupted.
- rst=0 asserted mid-STREAM for 1 clk -> next cycle all outputs 0 and state IDLE; no output until a new sync_in.
- With BITREV_READER_PINGPONG_EN, ADDR_W=3 -> rd_addr MSB is 0 for the first output frame, 1 for the second, 0 for the third; the lower bits match scenario 1.
